// File: rtl/systolic_feed_ctrl.sv
// Feed controller for a DEPTH x DEPTH systolic array: parallel-loads DEPTH row FIFOs,
// then shifts them out with a one-cycle skew per row, waits for the array to drain, and pulses done.
module systolic_feed_ctrl #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned DRAIN_CYC = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  output logic [$clog2(DEPTH)-1:0] wr_row,
  output logic [DEPTH-1:0]         wr_en,
  output logic [DEPTH-1:0]         shift_en,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned RW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(2 * DEPTH - 1 + DRAIN_CYC);

  localparam logic [RW-1:0] ROW_LAST   = RW'(DEPTH - 1);
  localparam logic [CW-1:0] FEED_LAST  = CW'(2 * DEPTH - 2);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(2 * DEPTH - 2 + DRAIN_CYC);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    FEED  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t        state, state_next;
  logic [RW-1:0] row_cnt, row_next;
  logic [CW-1:0] cyc_cnt, cyc_next;

  // State and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      row_cnt <= '0;
      cyc_cnt <= '0;
    end else begin
      state   <= state_next;
      row_cnt <= row_next;
      cyc_cnt <= cyc_next;
    end
  end

  // Next-state, counter update and output decode
  always_comb begin
    state_next = state;
    row_next   = row_cnt;
    cyc_next   = cyc_cnt;
    ld_ready   = 1'b0;
    wr_row     = '0;
    wr_en      = '0;
    shift_en   = '0;
    busy       = 1'b0;
    done       = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          state_next = LOAD;
          row_next   = '0;
        end
      end
      LOAD: begin
        ld_ready = 1'b1;
        wr_row   = row_cnt;
        if (ld_valid) begin
          wr_en = DEPTH'(1) << row_cnt;
          if (row_cnt == ROW_LAST) begin
            state_next = FEED;
            row_next   = '0;
            cyc_next   = '0;
          end else begin
            row_next = row_cnt + RW'(1);
          end
        end
      end
      FEED: begin
        // Row i is live for DEPTH cycles starting at cyc_cnt == i
        for (int unsigned i = 0; i < DEPTH; i++) begin
          shift_en[i] = (cyc_cnt >= CW'(i)) && (cyc_cnt <= CW'(i + DEPTH - 1));
        end
        cyc_next = cyc_cnt + CW'(1);
        if (cyc_cnt == FEED_LAST) state_next = DRAIN;
      end
      DRAIN: begin
        if (cyc_cnt == DRAIN_LAST) state_next = DONE;
        else                       cyc_next   = cyc_cnt + CW'(1);
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    busy = (state != IDLE);

    // Outputs are quiet for the whole reset cycle, even if the state was mid-pass
    if (rst) begin
      ld_ready = 1'b0;
      wr_row   = '0;
      wr_en    = '0;
      shift_en = '0;
      busy     = 1'b0;
      done     = 1'b0;
    end
  end

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Bench for systolic_feed_ctrl: directed passes plus random stimulus, checked against a
// pass-timeline model (rows loaded so far, then cycle offset since the last row was loaded).
module tb_systolic_feed_ctrl;

  localparam int D  = 8;
  localparam int DC = 8;
  localparam int RW = $clog2(D);
  localparam int FEED_LEN = 2 * D - 1;
  localparam int DONE_K   = FEED_LEN + DC;

  logic          clk = 1'b0;
  logic          rst, start, ld_valid;
  logic          ld_ready, busy, done;
  logic [RW-1:0] wr_row;
  logic [D-1:0]  wr_en, shift_en;

  systolic_feed_ctrl #(.DEPTH(D), .DRAIN_CYC(DC)) dut (
    .clk(clk), .rst(rst), .start(start), .ld_valid(ld_valid),
    .ld_ready(ld_ready), .wr_row(wr_row), .wr_en(wr_en), .shift_en(shift_en),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_cyc = -1;
  int shift_hi [D];
  logic prev_done = 1'b0;

  // Reference model: in a pass, first D handshakes load rows, then k counts cycles since
  bit m_active = 1'b0;
  int m_loaded = 0;
  int m_k      = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic run_cycle(input logic r, input logic s, input logic v);
    logic [D-1:0]  e_wr, e_sh;
    logic [RW-1:0] e_row;
    logic          e_rdy, e_busy, e_done;
    @(negedge clk);
    rst = r; start = s; ld_valid = v;
    #1;
    e_wr = '0; e_sh = '0; e_row = '0; e_rdy = 1'b0; e_busy = 1'b0; e_done = 1'b0;
    if (!r && m_active) begin
      e_busy = 1'b1;
      if (m_loaded < D) begin
        e_rdy = 1'b1;
        e_row = RW'(m_loaded);
        if (v) e_wr[m_loaded] = 1'b1;
      end else begin
        for (int i = 0; i < D; i++)
          e_sh[i] = (m_k < FEED_LEN) && (m_k >= i) && (m_k < i + D);
        e_done = (m_k == DONE_K);
      end
    end
    check("ld_ready", 32'(ld_ready), 32'(e_rdy));
    check("wr_row",   32'(wr_row),   32'(e_row));
    check("wr_en",    32'(wr_en),    32'(e_wr));
    check("shift_en", 32'(shift_en), 32'(e_sh));
    check("busy",     32'(busy),     32'(e_busy));
    check("done",     32'(done),     32'(e_done));
    check("inv_wr_onehot",  32'($onehot0(wr_en)), 32'd1);
    check("inv_wr_and_sh",  32'(wr_en & shift_en), 32'd0);
    check("inv_done_twice", 32'(prev_done & done), 32'd0);
    for (int i = 0; i < D; i++) if (shift_en[i]) shift_hi[i]++;
    if (done) done_cyc = cyc;
    prev_done = done;
    // model advance for the coming edge (inputs are held until then)
    if (r) begin
      m_active = 1'b0;
    end else if (!m_active) begin
      if (s) begin m_active = 1'b1; m_loaded = 0; m_k = 0; end
    end else if (m_loaded < D) begin
      if (v) m_loaded++;
    end else if (m_k == DONE_K) begin
      m_active = 1'b0;
    end else begin
      m_k++;
    end
    cyc++;
  endtask

  // One pass from a start in IDLE; returns start-to-done latency in cycles (-1 on timeout)
  task automatic do_pass(input int stall_after, input int stall_len, input bit poke_start,
                         output int lat);
    int s_cyc, hs, stalled;
    logic v, s;
    s_cyc = cyc; hs = 0; stalled = 0; done_cyc = -1; lat = -1;
    run_cycle(1'b0, 1'b1, 1'b0);
    for (int n = 0; n < 200 && done_cyc < 0; n++) begin
      v = 1'b1;
      if (hs == stall_after && stalled < stall_len) begin v = 1'b0; stalled++; end
      s = poke_start && (m_loaded == D) && (m_k == 3);
      if (v && m_active && m_loaded < D) hs++;
      run_cycle(1'b0, s, v);
    end
    if (done_cyc >= 0) lat = done_cyc - s_cyc;
    else check("pass_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int lat;
    rst = 1'b1; start = 1'b0; ld_valid = 1'b0;
    // reset dominates start and ld_valid
    run_cycle(1'b1, 1'b1, 1'b1);
    run_cycle(1'b1, 1'b1, 1'b1);
    run_cycle(1'b0, 1'b0, 1'b0);
    check("idle_after_reset", 32'(busy), 32'd0);

    // nominal pass and skew
    for (int i = 0; i < D; i++) shift_hi[i] = 0;
    do_pass(-1, 0, 1'b0, lat);
    check("nominal_latency", 32'(lat), 32'(1 + D + FEED_LEN + DC));
    for (int i = 0; i < D; i++) check("shift_bit_cycles", 32'(shift_hi[i]), 32'(D));
    run_cycle(1'b0, 1'b0, 1'b1);
    check("idle_after_done", 32'(busy), 32'd0);

    // load stall of 3 cycles after the 4th handshake
    do_pass(4, 3, 1'b0, lat);
    check("stall_latency", 32'(lat), 32'(1 + D + FEED_LEN + DC + 3));

    // start during FEED is ignored and not queued
    do_pass(-1, 0, 1'b1, lat);
    check("poke_latency", 32'(lat), 32'(1 + D + FEED_LEN + DC));
    for (int n = 0; n < 5; n++) run_cycle(1'b0, 1'b0, 1'b1);
    check("no_queued_start", 32'(busy), 32'd0);

    // reset at cyc_cnt=5 of FEED abandons the pass
    done_cyc = -1;
    run_cycle(1'b0, 1'b1, 1'b0);
    for (int n = 0; n < 100 && !(m_active && m_loaded == D && m_k == 5); n++)
      run_cycle(1'b0, 1'b0, 1'b1);
    run_cycle(1'b1, 1'b0, 1'b1);
    for (int n = 0; n < 40; n++) run_cycle(1'b0, 1'b0, 1'b1);
    check("no_done_after_rst", 32'(done_cyc), 32'hFFFF_FFFF);
    check("idle_after_mid_rst", 32'(busy), 32'd0);
    do_pass(-1, 0, 1'b0, lat);
    check("pass_after_rst_latency", 32'(lat), 32'(1 + D + FEED_LEN + DC));

    // random traffic
    for (int n = 0; n < 3000; n++)
      run_cycle(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 7) == 0),
                1'($urandom_range(0, 3) != 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/systolic_feed_ctrl.md
SYSTOLIC_FEED_CTRL -- requirements
Module: systolic_feed_ctrl

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8: number of row FIFOs and entries per FIFO; power of two, at least 2.
REQ-002 The block SHALL have parameter DRAIN_CYC, default 8: cycles allowed for the array to flush after the last feed; at least 1.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset: clk (input, 1 bit, rising-edge clock) and rst (input, 1 bit, synchronous active-high reset).
REQ-004 start  input  1  Request for one matrix pass; sampled in IDLE only.
REQ-005 ld_valid  input  1  Source presents a full DEPTH-entry row for the row FIFO selected by wr_row.
REQ-006 ld_ready  output  1  Controller accepts a row this cycle.
REQ-007 wr_row  output  $clog2(DEPTH)  Index of the row FIFO currently being loaded; drives the source data mux.
REQ-008 wr_en  output  DEPTH  One-hot parallel-load strobe, one bit per row FIFO.
REQ-009 shift_en  output  DEPTH  Per-FIFO shift strobe; also marks the FIFO head as valid array input.
REQ-010 busy  output  1  High in every state except IDLE.
REQ-011 done  output  1  Single-cycle completion pulse.

Function
REQ-012 The FSM SHALL have states IDLE, LOAD, FEED, DRAIN and DONE, plus counters row_cnt ($clog2(DEPTH) bits) and cyc_cnt ($clog2(2*DEPTH-1+DRAIN_CYC) bits).
REQ-013 In IDLE, start=1 SHALL move the FSM to LOAD on the next edge and clear row_cnt; start=0 SHALL hold IDLE.
REQ-014 In LOAD, ld_ready SHALL be 1 and wr_row SHALL equal row_cnt.
REQ-015 wr_en[row_cnt] SHALL equal ld_valid AND ld_ready, decoded combinationally in the same cycle; all other wr_en bits SHALL be 0.
REQ-016 A LOAD handshake (ld_valid and ld_ready both 1) SHALL increment row_cnt.
REQ-017 A handshake with row_cnt=DEPTH-1 SHALL move the FSM to FEED with cyc_cnt=0.
REQ-018 In LOAD, ld_valid=0 SHALL stall the FSM with row_cnt held and no wr_en asserted; LOAD has no timeout.
REQ-019 In FEED, shift_en[i] SHALL be 1 exactly when i <= cyc_cnt <= i+DEPTH-1, giving a one-cycle skew per row so that row i presents element k at cyc_cnt=i+k.
REQ-020 FEED SHALL last exactly 2*DEPTH-1 cycles (cyc_cnt 0..2*DEPTH-2), then move to DRAIN with cyc_cnt continuing to count.
REQ-021 DRAIN SHALL last exactly DRAIN_CYC cycles with shift_en=0, then move to DONE.
REQ-022 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-023 The FSM SHALL NOT accept a new start before it is back in IDLE; start while busy SHALL be ignored and not queued.
REQ-024 Outside LOAD, wr_en SHALL be 0 and ld_ready SHALL be 0; outside FEED, shift_en SHALL be 0.
REQ-025 wr_en and shift_en SHALL never both have any bit set in the same cycle.
REQ-026 Counters SHALL never wrap within a pass; cyc_cnt SHALL be cleared on entry to FEED.
REQ-027 Minimum pass latency SHALL be 1 + DEPTH + (2*DEPTH-1) + DRAIN_CYC cycles from the start sample to the done pulse, plus any LOAD stall cycles.

Reset
REQ-028 rst=1 at a clock edge SHALL force the FSM to IDLE and set row_cnt=0 and cyc_cnt=0.
REQ-029 While rst=1, all outputs SHALL be 0: ld_ready, wr_row, wr_en, shift_en, busy and done.
REQ-030 Reset SHALL take priority over start and ld_valid in the same cycle.
REQ-031 Reset asserted mid-pass SHALL abandon the pass without a done pulse; the next pass SHALL require a new start.

Verification
REQ-032 Nominal pass (DEPTH=8, DRAIN_CYC=8): start at cycle 0 with ld_valid held 1 -> wr_en one-hot 0x01..0x80 on cycles 1..8, FEED on cycles 9..23, DRAIN on cycles 24..31, done=1 on cycle 32 only, busy=0 on cycle 33.
REQ-033 Skew check: in FEED, shift_en=0x01 at cyc_cnt=0, 0xFF at cyc_cnt=7, 0x80 at cyc_cnt=14; each bit is high for exactly 8 cycles.
REQ-034 Load stall: ld_valid dropped for 3 cycles after the 4th handshake -> wr_row holds at 4, wr_en=0 during the stall, done is delayed by exactly 3 cycles (cycle 35).
REQ-035 Start while busy: start pulsed during FEED -> no effect; after DONE the FSM idles until a fresh start.
REQ-036 Reset mid-FEED: rst=1 at cyc_cnt=5 -> next cycle all outputs are 0 and the state is IDLE, no done pulse; a subsequent start runs a full nominal pass.
REQ-037 Invariant (checked every cycle): wr_en is zero or one-hot, wr_en AND shift_en is never nonzero, and done is never high on two consecutive cycles.
